// File: rtl/input_conditioner.sv
// input_conditioner: synchronize, debounce and strobe-decode board buttons and switches
// Ports:
//   clk, rst_n                  clock and synchronous active-low reset
//   btn_raw[N_BTN], sw_raw[N_SW] asynchronous pin inputs
//   btn_level, sw_level         debounced levels
//   btn_press, btn_release      one-cycle edge strobes aligned with the level change
//   btn_repeat                  press strobe plus auto-repeat strobes while held
//   sw_change                   one-cycle strobe when any switch level changes
module input_conditioner #(
    parameter int N_BTN           = 5,
    parameter int N_SW            = 16,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic [N_SW-1:0]  sw_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_repeat,
    output logic [N_SW-1:0]  sw_level,
    output logic             sw_change
);
    localparam int N    = N_BTN + N_SW;
    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] R_DELAY  = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] R_PERIOD = RW'(REPEAT_PERIOD);
    localparam logic [RW-1:0] R_ONE    = RW'(1);

    // Buttons occupy the low bits, switches the high bits of the shared pipeline.
    logic [N-1:0]     sync1_q, sync2_q, level_q, level_d;
    logic [DW-1:0]    db_cnt_q [N];
    logic [DW-1:0]    db_cnt_d [N];
    logic [RW-1:0]    rpt_cnt_q [N_BTN];
    logic [RW-1:0]    rpt_cnt_d [N_BTN];
    logic [N_BTN-1:0] press_q, press_d, release_q, release_d, repeat_q, repeat_d;
    logic             sw_change_q, sw_change_d;

    always_comb begin
        level_d = level_q;
        for (int i = 0; i < N; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != level_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) level_d[i] = sync2_q[i];
                else db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
        end
        // Strobes are registered from level_d so they coincide with the new level.
        press_d     = level_d[N_BTN-1:0] & ~level_q[N_BTN-1:0];
        release_d   = ~level_d[N_BTN-1:0] & level_q[N_BTN-1:0];
        sw_change_d = |(level_d[N-1:N_BTN] ^ level_q[N-1:N_BTN]);
        for (int i = 0; i < N_BTN; i++) begin
            rpt_cnt_d[i] = '0;
            repeat_d[i]  = 1'b0;
            if (press_d[i]) begin
                rpt_cnt_d[i] = R_DELAY;
                repeat_d[i]  = 1'b1;
            end else if (level_q[i] && level_d[i] && rpt_cnt_q[i] != '0) begin
                // A zero counter while held means auto-repeat is disabled.
                repeat_d[i]  = rpt_cnt_q[i] == R_ONE;
                rpt_cnt_d[i] = (rpt_cnt_q[i] == R_ONE) ? R_PERIOD : rpt_cnt_q[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            level_q     <= '0;
            press_q     <= '0;
            release_q   <= '0;
            repeat_q    <= '0;
            sw_change_q <= 1'b0;
            for (int i = 0; i < N; i++) db_cnt_q[i] <= '0;
            for (int i = 0; i < N_BTN; i++) rpt_cnt_q[i] <= '0;
        end else begin
            sync1_q     <= {sw_raw, btn_raw};
            sync2_q     <= sync1_q;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            repeat_q    <= repeat_d;
            sw_change_q <= sw_change_d;
            for (int i = 0; i < N; i++) db_cnt_q[i] <= db_cnt_d[i];
            for (int i = 0; i < N_BTN; i++) rpt_cnt_q[i] <= rpt_cnt_d[i];
        end
    end

    assign btn_level   = level_q[N_BTN-1:0];
    assign sw_level    = level_q[N-1:N_BTN];
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign btn_repeat  = repeat_q;
    assign sw_change   = sw_change_q;
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed, table-driven and randomized checks of input_conditioner
module tb_input_conditioner;
    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  btn_raw = '0;
    logic [15:0] sw_raw = '0;
    logic [4:0]  btn_level, btn_press, btn_release, btn_repeat;
    logic [15:0] sw_level;
    logic        sw_change;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    input_conditioner #(
        .N_BTN(5), .N_SW(16), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .sw_raw(sw_raw),
        .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
        .btn_repeat(btn_repeat), .sw_level(sw_level), .sw_change(sw_change)
    );

    always #5 clk = ~clk;

    // Reference model: raw samples pass through a two-deep delay, a level flips
    // after D consecutive disagreeing samples, and repeats follow the age since press.
    logic [20:0] m_s1 = '0, m_s2 = '0, m_lvl = '0;
    int          m_run [21];
    int          m_age [5];
    logic [4:0]  m_press = '0, m_rel = '0, m_rep = '0;
    logic        m_chg = 1'b0;

    task automatic model_edge();
        logic [20:0] old;
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_lvl = '0;
            m_press = '0; m_rel = '0; m_rep = '0; m_chg = 1'b0;
            for (int i = 0; i < 21; i++) m_run[i] = 0;
            for (int i = 0; i < 5; i++) m_age[i] = 0;
            return;
        end
        old = m_lvl;
        for (int i = 0; i < 21; i++) begin
            if (m_s2[i] != m_lvl[i]) begin
                m_run[i]++;
                if (m_run[i] == D) begin
                    m_lvl[i] = ~m_lvl[i];
                    m_run[i] = 0;
                end
            end else m_run[i] = 0;
        end
        m_s2 = m_s1;
        m_s1 = {sw_raw, btn_raw};
        m_press = m_lvl[4:0] & ~old[4:0];
        m_rel   = ~m_lvl[4:0] & old[4:0];
        m_chg   = |(m_lvl[20:5] ^ old[20:5]);
        for (int b = 0; b < 5; b++) begin
            if (m_press[b]) begin
                m_age[b] = 0;
                m_rep[b] = 1'b1;
            end else if (m_lvl[b]) begin
                m_age[b]++;
                m_rep[b] = RD > 0 && m_age[b] >= RD && (m_age[b] - RD) % RP == 0;
            end else m_rep[b] = 1'b0;
        end
    endtask

    task automatic tick();
        logic [36:0] act, exp;
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        act = {btn_level, btn_press, btn_release, btn_repeat, sw_level, sw_change};
        exp = {m_lvl[4:0], m_press, m_rel, m_rep, m_lvl[20:5], m_chg};
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL model cycle %0d: got %h expected %h", cyc, act, exp);
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [4:0]  btn;
        logic [15:0] sw;
        int          hold;
        logic [4:0]  exp_btn;
        logic [15:0] exp_sw;
    } vec_t;

    vec_t tbl [8];
    int   cnt;

    initial begin
        tbl[0] = '{5'h00, 16'h25A5, 8, 5'h00, 16'h25A5};
        tbl[1] = '{5'h1F, 16'hFFFF, 8, 5'h1F, 16'hFFFF};
        tbl[2] = '{5'h00, 16'h0000, 3, 5'h1F, 16'hFFFF};
        tbl[3] = '{5'h1F, 16'hFFFF, 8, 5'h1F, 16'hFFFF};
        tbl[4] = '{5'h0A, 16'h1234, 8, 5'h0A, 16'h1234};
        tbl[5] = '{5'h15, 16'h8001, 2, 5'h0A, 16'h1234};
        tbl[6] = '{5'h0A, 16'h1234, 8, 5'h0A, 16'h1234};
        tbl[7] = '{5'h00, 16'h0000, 8, 5'h00, 16'h0000};

        repeat (3) tick();
        chk("reset", {btn_level, btn_press, btn_release, btn_repeat, sw_level, sw_change}, 64'd0);
        rst_n = 1'b1;
        tick();

        // Clean press on C: accepted after edge 5 with press and repeat together.
        btn_raw[0] = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            tick();
            if (k < 5) chk("press_latency_level", btn_level[0], 1'b0);
        end
        chk("press_level", btn_level[0], 1'b1);
        chk("press_strobe", btn_press[0], 1'b1);
        chk("press_repeat", btn_repeat[0], 1'b1);
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 1) chk("press_width", btn_press[0], 1'b0);
            chk("repeat_cadence", btn_repeat[0], k == 10 || k == 13 || k == 16 || k == 19);
        end
        btn_raw[0] = 1'b0;
        for (int k = 0; k <= 7; k++) begin
            tick();
            chk("release_strobe", btn_release[0], k == 5);
            if (k >= 5) chk("no_repeat_after_release", btn_repeat[0], 1'b0);
        end

        // Bounce on L: toggling every 2 cycles is never accepted.
        for (int k = 0; k < 20; k++) begin
            if (k % 2 == 0) btn_raw[2] = ~btn_raw[2];
            tick();
            chk("bounce", {btn_level[2], btn_press[2], btn_release[2], btn_repeat[2]}, 4'b0);
        end
        btn_raw[2] = 1'b0;
        repeat (8) tick();
        chk("bounce_final", btn_level[2], 1'b0);

        // Switch bank: one change pulse per accepted update.
        sw_raw = 16'hA5A5;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin tick(); cnt += int'(sw_change); end
        chk("sw_level", sw_level, 16'hA5A5);
        chk("sw_change_count", cnt, 1);
        sw_raw[15] = 1'b0;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin tick(); cnt += int'(sw_change); end
        chk("sw_level2", sw_level, 16'h25A5);
        chk("sw_change_count2", cnt, 1);

        // Reset at debounce count 2, then a full re-debounce.
        btn_raw[1] = 1'b1;
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        chk("mid_reset", {btn_level, btn_press, btn_release, btn_repeat, sw_level, sw_change}, 64'd0);
        rst_n = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            tick();
            chk("post_reset_accept", btn_level[1], k == 5);
        end
        chk("post_reset_press", btn_press[1], 1'b1);
        btn_raw[1] = 1'b0;
        repeat (10) tick();

        // Multi-button: simultaneous presses and aligned repeats.
        btn_raw = 5'b10101;
        for (int k = 0; k <= 5; k++) tick();
        chk("multi_press", btn_press, 5'b10101);
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("multi_align", {btn_repeat[0], btn_repeat[2]}, {btn_repeat[4], btn_repeat[4]});
        end
        btn_raw = '0;
        repeat (10) tick();

        for (int t = 0; t < 8; t++) begin
            btn_raw = tbl[t].btn;
            sw_raw  = tbl[t].sw;
            repeat (tbl[t].hold) tick();
            chk("table_levels", {btn_level, sw_level}, {tbl[t].exp_btn, tbl[t].exp_sw});
        end

        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 5; b++)
                if ($urandom_range(0, 9) == 0) btn_raw[b] = ~btn_raw[b];
            if ($urandom_range(0, 15) == 0) sw_raw[$urandom_range(0, 15)] ^= 1'b1;
            rst_n = $urandom_range(0, 399) != 0;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
